if_fetch: RTL and testbench

- Instruction-fetch stage; sits directly upstream of the IF/ID pipeline register and drives its `pc` and `instruction` inputs.
- Owns the program counter and issues one instruction-memory read at a time over a request/response interface with variable latency.
- Holds a fetched word while the hazard unit stalls (`hz_write`), and redirects on taken branches/jumps from EX.
- Emits a NOP bubble whenever no valid instruction is available.

---
 rtl/if_fetch_pkg.sv | 19 +
 rtl/if_fetch.sv | 121 ++++++++++++
 tb/tb_if_fetch.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_pkg.sv
// Shared pipeline package: fetch FSM states and pipeline-wide constants.
// IF/ID and decode use the same bubble instruction defined here.
package if_fetch_pkg;

   localparam int WORD_BITWIDTH_DEFAULT = 32;

   // addi x0,x0,0
   localparam logic [31:0] NOP_INSN = 32'h00000013;

   localparam int PC_INCR = 4;

   typedef enum logic [1:0] {
      S_ISSUE,
      S_WAIT,
      S_HOLD,
      S_DROP
   } fetch_state_t;

endpackage

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, keeps one imem read in flight,
// holds the fetched word across stalls and drops stale responses.
module if_fetch #(
   parameter int WORD_BITWIDTH = if_fetch_pkg::WORD_BITWIDTH_DEFAULT,
   parameter logic [WORD_BITWIDTH-1:0] RESET_PC = '0,
   parameter logic [WORD_BITWIDTH-1:0] NOP_INSN =
      WORD_BITWIDTH'(if_fetch_pkg::NOP_INSN)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     hz_write,
   input  logic                     redirect_valid,
   input  logic [WORD_BITWIDTH-1:0] redirect_pc,
   output logic                     imem_req,
   output logic [WORD_BITWIDTH-1:0] imem_addr,
   input  logic                     imem_rvalid,
   input  logic [WORD_BITWIDTH-1:0] imem_rdata,
   output logic [WORD_BITWIDTH-1:0] pc,
   output logic [WORD_BITWIDTH-1:0] instruction,
   output logic                     fetch_valid
);

   import if_fetch_pkg::*;

   localparam logic [WORD_BITWIDTH-1:0] INCR = WORD_BITWIDTH'(PC_INCR);

   fetch_state_t             state;
   fetch_state_t             state_nxt;
   logic [WORD_BITWIDTH-1:0] pc_reg;
   logic [WORD_BITWIDTH-1:0] pc_nxt;
   logic [WORD_BITWIDTH-1:0] hold_buf;
   logic [WORD_BITWIDTH-1:0] hold_nxt;
   logic [WORD_BITWIDTH-1:0] target;

   // Redirect targets are forced to word alignment.
   assign target = {redirect_pc[WORD_BITWIDTH-1:2], 2'b00};

   // Next-state and output decode; redirect outranks stall and response.
   always_comb begin
      state_nxt   = state;
      pc_nxt      = pc_reg;
      hold_nxt    = hold_buf;
      imem_req    = 1'b0;
      imem_addr   = pc_reg;
      pc          = pc_reg;
      instruction = NOP_INSN;
      fetch_valid = 1'b0;

      if (redirect_valid) begin
         pc_nxt = target;
         unique case (state)
            S_ISSUE: begin
               // This cycle's request still goes out and must be drained.
               imem_req  = 1'b1;
               state_nxt = S_DROP;
            end
            S_WAIT: begin
               state_nxt = imem_rvalid ? S_ISSUE : S_DROP;
            end
            S_HOLD: begin
               state_nxt = S_ISSUE;
            end
            S_DROP: begin
               state_nxt = imem_rvalid ? S_ISSUE : S_DROP;
            end
         endcase
      end else begin
         unique case (state)
            S_ISSUE: begin
               imem_req  = 1'b1;
               state_nxt = S_WAIT;
            end
            S_WAIT: begin
               if (imem_rvalid) begin
                  instruction = imem_rdata;
                  fetch_valid = 1'b1;
                  if (hz_write) begin
                     hold_nxt  = imem_rdata;
                     state_nxt = S_HOLD;
                  end else begin
                     pc_nxt    = pc_reg + INCR;
                     state_nxt = S_ISSUE;
                  end
               end
            end
            S_HOLD: begin
               instruction = hold_buf;
               fetch_valid = 1'b1;
               if (!hz_write) begin
                  pc_nxt    = pc_reg + INCR;
                  state_nxt = S_ISSUE;
               end
            end
            S_DROP: begin
               if (imem_rvalid) begin
                  state_nxt = S_ISSUE;
               end
            end
         endcase
      end

      // Reset parks the FSM in ISSUE; keep the request quiet meanwhile.
      if (rst) begin
         imem_req = 1'b0;
      end
   end

   // State, PC and hold buffer registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_ISSUE;
         pc_reg   <= RESET_PC;
         hold_buf <= '0;
      end else begin
         state    <= state_nxt;
         pc_reg   <= pc_nxt;
         hold_buf <= hold_nxt;
      end
   end

endmodule

// File: tb/tb_if_fetch.sv
// Directed vector bench for if_fetch: table of per-cycle inputs and
// expected outputs, plus hand-written reset sequences.
module tb_if_fetch;

   localparam logic [31:0] NOP = 32'h00000013;

   logic        clk;
   logic        rst;
   logic        hz_write;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic [31:0] pc;
   logic [31:0] instruction;
   logic        fetch_valid;

   int n_tests;
   int n_fail;

   typedef struct {
      logic        hz;
      logic        rv;
      logic [31:0] rpc;
      logic        mv;
      logic [31:0] md;
      logic        e_req;
      logic [31:0] e_addr;
      logic [31:0] e_pc;
      logic [31:0] e_insn;
      logic        e_fv;
   } vec_t;

   vec_t vecs[$];

   if_fetch dut (
      .clk            (clk),
      .rst            (rst),
      .hz_write       (hz_write),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_rvalid    (imem_rvalid),
      .imem_rdata     (imem_rdata),
      .pc             (pc),
      .instruction    (instruction),
      .fetch_valid    (fetch_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", nm, got, exp);
      end
   endtask

   task automatic add(input logic hz, input logic rv, input logic [31:0] rpc,
                      input logic mv, input logic [31:0] md,
                      input logic e_req, input logic [31:0] e_addr,
                      input logic [31:0] e_pc, input logic [31:0] e_insn,
                      input logic e_fv);
      vec_t v;
      v.hz = hz; v.rv = rv; v.rpc = rpc; v.mv = mv; v.md = md;
      v.e_req = e_req; v.e_addr = e_addr; v.e_pc = e_pc;
      v.e_insn = e_insn; v.e_fv = e_fv;
      vecs.push_back(v);
   endtask

   task automatic chk_row(input string tag, input logic e_req,
                          input logic [31:0] e_addr, input logic [31:0] e_pc,
                          input logic [31:0] e_insn, input logic e_fv);
      chk({tag, " req"}, 32'(imem_req), 32'(e_req));
      if (e_req) chk({tag, " addr"}, imem_addr, e_addr);
      chk({tag, " pc"}, pc, e_pc);
      chk({tag, " insn"}, instruction, e_insn);
      chk({tag, " fv"}, 32'(fetch_valid), 32'(e_fv));
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst = 1'b1;
      hz_write = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc = '0;
      imem_rvalid = 1'b0;
      imem_rdata = '0;

      //   hz rv rpc           mv md           req addr          pc            insn          fv
      // 1-cycle memory: addresses 0, 4, 8
      add(0, 0, 0,            0, 0,            1, 32'h0,        32'h0,        NOP,          0);
      add(0, 0, 0,            1, 32'h00100093, 0, 0,            32'h0,        32'h00100093, 1);
      add(0, 0, 0,            0, 0,            1, 32'h4,        32'h4,        NOP,          0);
      add(0, 0, 0,            1, 32'h00200113, 0, 0,            32'h4,        32'h00200113, 1);
      add(0, 0, 0,            0, 0,            1, 32'h8,        32'h8,        NOP,          0);
      // stall 3 cycles starting in the rvalid cycle of address 8
      add(1, 0, 0,            1, 32'hAAAA0001, 0, 0,            32'h8,        32'hAAAA0001, 1);
      add(1, 0, 0,            0, 0,            0, 0,            32'h8,        32'hAAAA0001, 1);
      add(1, 0, 0,            0, 0,            0, 0,            32'h8,        32'hAAAA0001, 1);
      add(0, 0, 0,            0, 0,            0, 0,            32'h8,        32'hAAAA0001, 1);
      add(0, 0, 0,            0, 0,            1, 32'hC,        32'hC,        NOP,          0);
      add(0, 0, 0,            1, 32'hBBBB000C, 0, 0,            32'hC,        32'hBBBB000C, 1);
      // 3-cycle memory, redirect to 0x40 while 0x10 is pending
      add(0, 0, 0,            0, 0,            1, 32'h10,       32'h10,       NOP,          0);
      add(0, 0, 0,            0, 0,            0, 0,            32'h10,       NOP,          0);
      add(0, 1, 32'h40,       0, 0,            0, 0,            32'h10,       NOP,          0);
      add(0, 0, 0,            1, 32'hDEAD0010, 0, 0,            32'h40,       NOP,          0);
      add(0, 0, 0,            0, 0,            1, 32'h40,       32'h40,       NOP,          0);
      // redirect with rvalid in the same WAIT cycle; target unaligned
      add(0, 1, 32'h81,       1, 32'h12345678, 0, 0,            32'h40,       NOP,          0);
      add(0, 0, 0,            0, 0,            1, 32'h80,       32'h80,       NOP,          0);
      // redirect in HOLD while stalled
      add(1, 0, 0,            1, 32'h0BADF00D, 0, 0,            32'h80,       32'h0BADF00D, 1);
      add(1, 1, 32'h200,      0, 0,            0, 0,            32'h80,       NOP,          0);
      add(1, 0, 0,            0, 0,            1, 32'h200,      32'h200,      NOP,          0);
      add(0, 0, 0,            1, 32'h00000513, 0, 0,            32'h200,      32'h00000513, 1);
      // redirect from ISSUE to the top word, then wrap
      add(0, 1, 32'hFFFFFFFE, 0, 0,            1, 32'h204,      32'h204,      NOP,          0);
      add(0, 0, 0,            1, 32'h00000055, 0, 0,            32'hFFFFFFFC, NOP,          0);
      add(0, 0, 0,            0, 0,            1, 32'hFFFFFFFC, 32'hFFFFFFFC, NOP,          0);
      add(0, 0, 0,            1, 32'h00300193, 0, 0,            32'hFFFFFFFC, 32'h00300193, 1);
      // rvalid during ISSUE is ignored
      add(0, 0, 0,            1, 32'h00000077, 1, 32'h0,        32'h0,        NOP,          0);
      add(0, 0, 0,            0, 0,            0, 0,            32'h0,        NOP,          0);
      add(0, 0, 0,            1, 32'h00400213, 0, 0,            32'h0,        32'h00400213, 1);
      add(0, 0, 0,            0, 0,            1, 32'h4,        32'h4,        NOP,          0);
      add(0, 0, 0,            0, 0,            0, 0,            32'h4,        NOP,          0);

      // reset state, across a clock edge
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      chk_row("reset", 1'b0, 32'h0, 32'h0, NOP, 1'b0);

      rst = 1'b0;
      foreach (vecs[i]) begin
         if (i != 0) @(negedge clk);
         hz_write       = vecs[i].hz;
         redirect_valid = vecs[i].rv;
         redirect_pc    = vecs[i].rpc;
         imem_rvalid    = vecs[i].mv;
         imem_rdata     = vecs[i].md;
         #1;
         chk_row($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr,
                 vecs[i].e_pc, vecs[i].e_insn, vecs[i].e_fv);
      end

      // async reset while WAIT is presenting a live response for pc 4
      @(negedge clk);
      hz_write       = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      imem_rvalid    = 1'b1;
      imem_rdata     = 32'hCAFE0001;
      #1;
      chk_row("pre_rst", 1'b0, 32'h0, 32'h4, 32'hCAFE0001, 1'b1);
      #1;
      rst = 1'b1;
      #1;
      chk_row("async_rst", 1'b0, 32'h0, 32'h0, NOP, 1'b0);
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
      @(negedge clk);
      #1;
      chk_row("rst_hold", 1'b0, 32'h0, 32'h0, NOP, 1'b0);
      rst = 1'b0;
      #1;
      chk_row("post_rst", 1'b1, 32'h0, 32'h0, NOP, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
